// File: rtl/bf_result_checker.sv
// Result checker for the Bellman-Ford harness: done/timeout watchdog, word-by-word
// compare of the output memory against an expected memory, and negative-cycle flag check.
module bf_result_checker #(
   parameter int ADDR_W         = 13,
   parameter int DATA_W         = 16,
   parameter int NUM_WORDS      = 64,
   parameter int START_ADDR     = 0,
   parameter int TIMEOUT_CYCLES = 700,
   parameter int SKIP_ON_NEG    = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              done_in,
   input  logic              NegCycle,
   input  logic              expected_neg,
   output logic [ADDR_W-1:0] OMAR,
   input  logic [DATA_W-1:0] OMDR,
   output logic [ADDR_W-1:0] EMAR,
   input  logic [DATA_W-1:0] EMDR,
   output logic              busy,
   output logic              check_done,
   output logic              pass,
   output logic              fail,
   output logic              timeout,
   output logic              neg_mismatch,
   output logic [ADDR_W:0]   mismatch_count,
   output logic [ADDR_W-1:0] first_addr,
   output logic [DATA_W-1:0] first_got,
   output logic [DATA_W-1:0] first_exp
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int IDX_W = ADDR_W + 1;

   typedef enum logic [1:0] {
      S_WAIT,
      S_SCAN,
      S_DONE
   } state_t;

   function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
      return (&v) ? v : v + {{ADDR_W{1'b0}}, 1'b1};
   endfunction

   state_t              state_q,  state_d;
   logic [CNT_W-1:0]    wcnt_q,   wcnt_d;
   logic [IDX_W-1:0]    idx_q,    idx_d;
   logic [ADDR_W-1:0]   addr_q,   addr_d;
   logic                busy_q,   busy_d;
   logic                cdone_q,  cdone_d;
   logic                pass_q,   pass_d;
   logic                fail_q,   fail_d;
   logic                to_q,     to_d;
   logic                negm_q,   negm_d;
   logic [ADDR_W:0]     mcnt_q,   mcnt_d;
   logic [ADDR_W-1:0]   faddr_q,  faddr_d;
   logic [DATA_W-1:0]   fgot_q,   fgot_d;
   logic [DATA_W-1:0]   fexp_q,   fexp_d;

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      to_d    = to_q;
      negm_d  = negm_q;
      mcnt_d  = mcnt_q;
      faddr_d = faddr_q;
      fgot_d  = fgot_q;
      fexp_d  = fexp_q;

      case (state_q)
         S_WAIT: begin
            wcnt_d = wcnt_q + 1'b1;
            // done_in has priority over a timeout landing on the same edge
            if (done_in) begin
               negm_d = NegCycle ^ expected_neg;
               if ((SKIP_ON_NEG != 0) && NegCycle && expected_neg) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_SCAN;
               end
            end else if (wcnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_d = S_DONE;
               to_d    = 1'b1;
            end
         end
         S_SCAN: begin
            if (OMDR != EMDR) begin
               mcnt_d = sat_inc(mcnt_q);
               if (mcnt_q == '0) begin
                  faddr_d = addr_q;
                  fgot_d  = OMDR;
                  fexp_d  = EMDR;
               end
            end
            addr_d = addr_q + 1'b1;
            idx_d  = idx_q + 1'b1;
            if (idx_q == IDX_W'(NUM_WORDS - 1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: begin
            state_d = S_WAIT;
         end
      endcase

      // Status flags are registered from next-state values so DONE entry shows final results
      busy_d  = (state_d != S_DONE);
      cdone_d = (state_d == S_DONE);
      pass_d  = cdone_d && (mcnt_d == '0) && !negm_d && !to_d;
      fail_d  = cdone_d && !pass_d;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_WAIT;
         wcnt_q  <= '0;
         idx_q   <= '0;
         addr_q  <= ADDR_W'(START_ADDR);
         busy_q  <= 1'b1;
         cdone_q <= 1'b0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
         to_q    <= 1'b0;
         negm_q  <= 1'b0;
         mcnt_q  <= '0;
         faddr_q <= '0;
         fgot_q  <= '0;
         fexp_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         busy_q  <= busy_d;
         cdone_q <= cdone_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         to_q    <= to_d;
         negm_q  <= negm_d;
         mcnt_q  <= mcnt_d;
         faddr_q <= faddr_d;
         fgot_q  <= fgot_d;
         fexp_q  <= fexp_d;
      end
   end

   assign OMAR           = addr_q;
   assign EMAR           = addr_q;
   assign busy           = busy_q;
   assign check_done     = cdone_q;
   assign pass           = pass_q;
   assign fail           = fail_q;
   assign timeout        = to_q;
   assign neg_mismatch   = negm_q;
   assign mismatch_count = mcnt_q;
   assign first_addr     = faddr_q;
   assign first_got      = fgot_q;
   assign first_exp      = fexp_q;

endmodule

// File: tb/tb_bf_result_checker.sv
// Bench for bf_result_checker: two instances (plain start / wrapping start) share
// clock, reset, done and memories; outputs are checked every cycle against a timing model.
module tb_bf_result_checker;

   localparam int AW  = 13;
   localparam int DW  = 16;
   localparam int TMO = 50;
   localparam int NWA = 8;
   localparam int SA  = 0;
   localparam int NWB = 4;
   localparam int SB  = 8190;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic done_in = 1'b0;
   logic neg_in = 1'b0;
   logic eneg_in = 1'b0;

   always #5 clk = ~clk;

   logic [DW-1:0] omem [0:8191];
   logic [DW-1:0] emem [0:8191];

   logic [AW-1:0] omar_a, emar_a, fa_a, omar_b, emar_b, fa_b;
   logic [DW-1:0] omdr_a, emdr_a, fg_a, fe_a, omdr_b, emdr_b, fg_b, fe_b;
   logic [AW:0]   mc_a, mc_b;
   logic bz_a, cd_a, ps_a, fl_a, to_a, nm_a;
   logic bz_b, cd_b, ps_b, fl_b, to_b, nm_b;

   assign omdr_a = omem[omar_a];
   assign emdr_a = emem[emar_a];
   assign omdr_b = omem[omar_b];
   assign emdr_b = emem[emar_b];

   bf_result_checker #(.ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(NWA), .START_ADDR(SA),
                       .TIMEOUT_CYCLES(TMO), .SKIP_ON_NEG(1)) dut_a (
      .clock(clk), .reset(reset), .done_in(done_in), .NegCycle(neg_in),
      .expected_neg(eneg_in), .OMAR(omar_a), .OMDR(omdr_a), .EMAR(emar_a),
      .EMDR(emdr_a), .busy(bz_a), .check_done(cd_a), .pass(ps_a), .fail(fl_a),
      .timeout(to_a), .neg_mismatch(nm_a), .mismatch_count(mc_a),
      .first_addr(fa_a), .first_got(fg_a), .first_exp(fe_a));

   bf_result_checker #(.ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(NWB), .START_ADDR(SB),
                       .TIMEOUT_CYCLES(TMO), .SKIP_ON_NEG(0)) dut_b (
      .clock(clk), .reset(reset), .done_in(done_in), .NegCycle(neg_in),
      .expected_neg(eneg_in), .OMAR(omar_b), .OMDR(omdr_b), .EMAR(emar_b),
      .EMDR(emdr_b), .busy(bz_b), .check_done(cd_b), .pass(ps_b), .fail(fl_b),
      .timeout(to_b), .neg_mismatch(nm_b), .mismatch_count(mc_b),
      .first_addr(fa_b), .first_got(fg_b), .first_exp(fe_b));

   // Edges taken out of reset; 0 while reset is being applied
   int ecnt = 0;
   always @(posedge clk) begin
      if (reset) ecnt <= 0;
      else       ecnt <= ecnt + 1;
   end

   int scn = 0;
   int sd = 0;
   bit sng = 1'b0;
   bit sen = 1'b0;
   bit chk_en = 1'b0;
   int total = 0;
   int bad = 0;
   int wrap_addr[4] = '{8190, 8191, 0, 1};

   typedef struct {
      int busy, cd, pass, fail, to, negm, omar, cnt, fa, fg, fe;
   } exp_t;

   exp_t ea, eb;

   // Expected outputs after e edges, given the edge d that first samples done_in (0 = never)
   function automatic exp_t model(input int e, input int d, input bit ng, input bit en,
                                  input int start, input int nw, input bit skip);
      exp_t r;
      int k;
      bit fin;
      r = '{busy: 1, cd: 0, pass: 0, fail: 0, to: 0, negm: 0, omar: start % 8192,
            cnt: 0, fa: 0, fg: 0, fe: 0};
      if (e == 0) return r;
      if (d < 1 || d > TMO) begin
         if (e >= TMO) begin
            r.busy = 0; r.cd = 1; r.to = 1; r.fail = 1;
         end
         return r;
      end
      if (e < d) return r;
      r.negm = (ng != en) ? 1 : 0;
      if (skip && ng && en) begin
         k = 0;
         fin = 1'b1;
      end else begin
         k = (e - d < nw) ? e - d : nw;
         fin = (e - d) >= nw;
      end
      for (int i = 0; i < k; i++) begin
         int a;
         a = (start + i) % 8192;
         if (omem[a] != emem[a]) begin
            if (r.cnt == 0) begin
               r.fa = a; r.fg = int'(omem[a]); r.fe = int'(emem[a]);
            end
            r.cnt++;
         end
      end
      r.omar = (start + k) % 8192;
      if (fin) begin
         r.busy = 0;
         r.cd = 1;
         r.pass = (r.cnt == 0 && r.negm == 0) ? 1 : 0;
         r.fail = 1 - r.pass;
      end
      return r;
   endfunction

   task automatic chk(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (scenario %0d edge %0d)", nm, act, req, scn, ecnt);
      end
   endtask

   task automatic chk_dut(input string t, input exp_t x, input logic bz, cd, ps, fl, tout, nm,
                          input logic [AW-1:0] om, em, input logic [AW:0] mc,
                          input logic [AW-1:0] fa, input logic [DW-1:0] fg, fe);
      chk({t, " busy"}, int'(bz), x.busy);
      chk({t, " check_done"}, int'(cd), x.cd);
      chk({t, " pass"}, int'(ps), x.pass);
      chk({t, " fail"}, int'(fl), x.fail);
      chk({t, " timeout"}, int'(tout), x.to);
      chk({t, " neg_mismatch"}, int'(nm), x.negm);
      chk({t, " OMAR"}, int'(om), x.omar);
      chk({t, " EMAR"}, int'(em), x.omar);
      chk({t, " mismatch_count"}, int'(mc), x.cnt);
      chk({t, " first_addr"}, int'(fa), x.fa);
      chk({t, " first_got"}, int'(fg), x.fg);
      chk({t, " first_exp"}, int'(fe), x.fe);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         ea = model(ecnt, sd, sng, sen, SA, NWA, 1'b1);
         eb = model(ecnt, sd, sng, sen, SB, NWB, 1'b0);
         chk_dut("A", ea, bz_a, cd_a, ps_a, fl_a, to_a, nm_a, omar_a, emar_a, mc_a, fa_a, fg_a, fe_a);
         chk_dut("B", eb, bz_b, cd_b, ps_b, fl_b, to_b, nm_b, omar_b, emar_b, mc_b, fa_b, fg_b, fe_b);

         // Hand-derived anchors for the directed scenarios
         if (scn == 1 && ecnt == 28) chk("s1 A done early", int'(cd_a), 0);
         if (scn == 1 && ecnt == 29) begin
            chk("s1 A check_done", int'(cd_a), 1);
            chk("s1 A pass", int'(ps_a), 1);
            chk("s1 A count", int'(mc_a), 0);
         end
         if (scn == 1 && ecnt >= 21 && ecnt <= 24) chk("s1 B wrap addr", int'(omar_b), wrap_addr[ecnt-21]);
         if (scn == 1 && ecnt == 25) chk("s1 B check_done", int'(cd_b), 1);
         if (scn == 2 && ecnt == 19) begin
            chk("s2 count", int'(mc_a), 2);
            chk("s2 first_addr", int'(fa_a), 3);
            chk("s2 first_got", int'(fg_a), 5);
            chk("s2 first_exp", int'(fe_a), 4);
            chk("s2 fail", int'(fl_a), 1);
         end
         if (scn == 3 && ecnt == 49) chk("s3 done early", int'(cd_a), 0);
         if (scn == 3 && ecnt == 50) begin
            chk("s3 check_done", int'(cd_a), 1);
            chk("s3 timeout", int'(to_a), 1);
            chk("s3 pass", int'(ps_a), 0);
         end
         if (scn == 4 && ecnt == 9) chk("s4 done early", int'(cd_a), 0);
         if (scn == 4 && ecnt == 10) begin
            chk("s4 check_done", int'(cd_a), 1);
            chk("s4 pass", int'(ps_a), 1);
            chk("s4 OMAR", int'(omar_a), 0);
            chk("s4 B still busy", int'(bz_b), 1);
         end
         if (scn == 5 && ecnt == 19) begin
            chk("s5 neg_mismatch", int'(nm_a), 1);
            chk("s5 fail", int'(fl_a), 1);
         end
         if (scn == 6 && ecnt == 50) begin
            chk("s6 timeout", int'(to_a), 0);
            chk("s6 busy", int'(bz_a), 1);
         end
         if (scn == 6 && ecnt == 58) chk("s6 pass", int'(ps_a), 1);
         if (scn == 7 && ecnt == 15 && !reset) chk("s7 count mid-scan", int'(mc_a), 1);
         if (scn == 7 && reset && ecnt == 0) begin
            chk("s7 reset count", int'(mc_a), 0);
            chk("s7 reset first_addr", int'(fa_a), 0);
            chk("s7 reset OMAR", int'(omar_a), 0);
            chk("s7 reset busy", int'(bz_a), 1);
         end
         if (scn == 8 && ecnt == 6) chk("s8 restart OMAR", int'(omar_a), 1);
         if (scn == 8 && ecnt == 13) begin
            chk("s8 check_done", int'(cd_a), 1);
            chk("s8 first_addr", int'(fa_a), 2);
            chk("s8 fail", int'(fl_a), 1);
         end
      end
   end

   task automatic fill(input bit allow_mm);
      for (int i = 0; i < 10; i++) begin
         int a;
         logic [DW-1:0] v;
         a = (i < 8) ? i : 8182 + i;
         v = DW'($urandom);
         omem[a] = v;
         emem[a] = v;
         if (allow_mm && $urandom_range(3) == 0) emem[a] = v ^ DW'(1 << $urandom_range(15));
      end
   endtask

   task automatic begin_reset();
      reset = 1'b1;
      done_in = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic release_scn(input int id, input int d, input bit ng, input bit en);
      @(posedge clk);
      #1;
      scn = id; sd = d; sng = ng; sen = en;
      neg_in = ng; eneg_in = en;
      reset = 1'b0;
   endtask

   task automatic run(input int n, input int len);
      for (int c = 1; c <= n; c++) begin
         done_in = (sd > 0 && c >= sd && c < sd + len);
         @(posedge clk);
         #1;
      end
      done_in = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 8192; i++) begin
         omem[i] = '0;
         emem[i] = '0;
      end
      @(posedge clk);
      #1;
      chk_en = 1'b1;

      begin_reset(); fill(1'b0);
      release_scn(1, 21, 1'b0, 1'b0); run(70, 1);

      begin_reset(); fill(1'b0);
      omem[3] = 16'h0005; emem[3] = 16'h0004;
      omem[6] = emem[6] ^ 16'h00F0;
      release_scn(2, 10, 1'b0, 1'b0); run(70, 1);

      begin_reset(); fill(1'b1);
      release_scn(3, 0, 1'b0, 1'b0); run(70, 1);

      begin_reset(); fill(1'b0);
      release_scn(4, 10, 1'b1, 1'b1); run(70, 2);

      begin_reset(); fill(1'b0);
      release_scn(5, 10, 1'b0, 1'b1); run(70, 1);

      begin_reset(); fill(1'b0);
      release_scn(6, 50, 1'b0, 1'b0); run(70, 1);

      begin_reset(); fill(1'b0);
      omem[2] = emem[2] ^ 16'h0001;
      release_scn(7, 10, 1'b0, 1'b0); run(15, 1);
      begin_reset();
      release_scn(8, 5, 1'b0, 1'b0); run(70, 1);

      begin_reset(); fill(1'b1);
      release_scn(9, 51, 1'b0, 1'b0); run(70, 3);

      for (int s = 0; s < 40; s++) begin
         int d;
         begin_reset(); fill(1'b1);
         d = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(55, 1));
         release_scn(100 + s, d, 1'($urandom_range(1)), 1'($urandom_range(1)));
         run(70, int'($urandom_range(3, 1)));
      end

      chk_en = 1'b0;
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
